// File: rtl/ga_alu_arbiter_if.sv
// Shared GA types and the requester-side bus of ga_alu_arbiter.
// ga_pkg holds the operation encoding and the multivector layout used by ga_alu.
// ga_alu_arbiter_if bundles the per-requester request/response handshake;
// the requesters sit on the master modport and the arbiter on the slave modport.

package ga_pkg;

   // Operation selector understood by ga_alu.
   typedef enum logic [2:0] {
      GA_ADD     = 3'd0,
      GA_SUB     = 3'd1,
      GA_GEOM    = 3'd2,
      GA_OUTER   = 3'd3,
      GA_INNER   = 3'd4,
      GA_REVERSE = 3'd5,
      GA_DUAL    = 3'd6,
      GA_INV     = 3'd7
   } ga_funct_e;

   // Full 3D multivector: scalar, vector, bivector and pseudoscalar parts.
   typedef struct packed {
      logic [15:0] scalar;
      logic [15:0] e1;
      logic [15:0] e2;
      logic [15:0] e3;
      logic [15:0] e12;
      logic [15:0] e23;
      logic [15:0] e31;
      logic [15:0] e123;
   } ga_multivector_t;

endpackage

interface ga_alu_arbiter_if #(
   parameter int NumReq = 2
);
   import ga_pkg::*;

   logic            [NumReq-1:0] req_valid;
   logic            [NumReq-1:0] req_ready;
   ga_funct_e       [NumReq-1:0] req_op;
   ga_multivector_t [NumReq-1:0] req_a;
   ga_multivector_t [NumReq-1:0] req_b;
   logic            [NumReq-1:0] rsp_valid;
   logic            [NumReq-1:0] rsp_ready;
   ga_multivector_t              rsp_result;
   logic                         rsp_error;

   modport master (
      output req_valid, req_op, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_result, rsp_error
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_result, rsp_error
   );

endinterface

// File: rtl/ga_alu_arbiter.sv
// ga_alu_arbiter: round-robin sharing of one ga_alu between NumReq requesters.
// IDLE picks a requester and latches its operands, ISSUE drives the ALU
// valid/ready handshake, WAIT counts out the ALU latency and captures the
// result, RESP holds the result for the winner until it is taken.
// Integration: drive ga_alu rst_ni with ~rst_i so both blocks reset together.
// Optional feature macro: GA_ALU_ARB_TIMEOUT_EN enables an ISSUE watchdog that
// ends a stalled handshake after TimeoutCycles with an error response.

module ga_alu_arbiter
   import ga_pkg::*;
#(
   parameter int NumReq        = 2,
   parameter int AluLatency    = 2,
   parameter int TimeoutCycles = 15
) (
   input  logic            clk_i,
   input  logic            rst_i,
   ga_alu_arbiter_if.slave bus,
   output logic            alu_valid_o,
   input  logic            alu_ready_i,
   output ga_funct_e       alu_op_o,
   output ga_multivector_t alu_a_o,
   output ga_multivector_t alu_b_o,
   input  ga_multivector_t alu_result_i,
   input  logic            alu_error_i,
   output logic            busy_o
);

   localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
   // One counter serves both the WAIT latency countdown and the ISSUE
   // watchdog, since the two states never overlap.
   localparam int CntMax = (AluLatency > TimeoutCycles) ? AluLatency : TimeoutCycles;
   localparam int CntW   = $clog2(CntMax + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [IdxW-1:0] ptr_q, ptr_d;
   logic [IdxW-1:0] gnt_q, gnt_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [NumReq-1:0] req_ready_q, req_ready_d;
   logic [NumReq-1:0] rsp_valid_q, rsp_valid_d;
   logic            alu_valid_q, alu_valid_d;
   logic            rsp_error_q, rsp_error_d;
   logic            busy_q, busy_d;
   ga_funct_e       op_q, op_d;
   ga_multivector_t a_q, a_d;
   ga_multivector_t b_q, b_d;
   ga_multivector_t result_q, result_d;

   logic            sel_found;
   logic [IdxW-1:0] sel_idx;

   function automatic logic [NumReq-1:0] idx_to_onehot(input logic [IdxW-1:0] idx);
      logic [NumReq-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

   // Round-robin pick: first requesting index at or after the pointer, wrapping.
   always_comb begin
      int   cand;
      logic hit;
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = 0;
      hit       = 1'b0;
      for (int i = 0; i < NumReq; i++) begin
         cand      = ((int'(ptr_q) + i) >= NumReq) ? (int'(ptr_q) + i - NumReq) : (int'(ptr_q) + i);
         hit       = !sel_found && bus.req_valid[IdxW'(cand)];
         sel_idx   = hit ? IdxW'(cand) : sel_idx;
         sel_found = sel_found | hit;
      end
   end

   // Next-state and next-output logic for the arbitration FSM.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      gnt_d       = gnt_q;
      cnt_d       = cnt_q;
      req_ready_d = '0;
      rsp_valid_d = rsp_valid_q;
      alu_valid_d = 1'b0;
      rsp_error_d = rsp_error_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      result_d    = result_q;

      case (state_q)
         ST_IDLE: begin
            if (sel_found) begin
               state_d              = ST_ISSUE;
               gnt_d                = sel_idx;
               ptr_d                = (sel_idx == IdxW'(NumReq - 1)) ? '0 : sel_idx + 1'b1;
               req_ready_d          = idx_to_onehot(sel_idx);
               op_d                 = bus.req_op[sel_idx];
               a_d                  = bus.req_a[sel_idx];
               b_d                  = bus.req_b[sel_idx];
               cnt_d                = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_ISSUE: begin
            if (alu_valid_q && alu_ready_i) begin
               // Handshake cycle: the result is due AluLatency cycles from here.
               state_d = ST_WAIT;
               cnt_d   = CntW'(AluLatency - 1);
`ifdef GA_ALU_ARB_TIMEOUT_EN
            end else if (alu_valid_q && (cnt_q == CntW'(TimeoutCycles))) begin
               // ALU never accepted: answer the requester with an error.
               state_d     = ST_RESP;
               rsp_valid_d = idx_to_onehot(gnt_q);
               result_d    = '0;
               rsp_error_d = 1'b1;
            end else begin
               alu_valid_d = 1'b1;
               cnt_d       = alu_valid_q ? cnt_q + 1'b1 : cnt_q;
            end
`else
            end else begin
               alu_valid_d = 1'b1;
            end
`endif
         end

         ST_WAIT: begin
            if (cnt_q == '0) begin
               state_d     = ST_RESP;
               rsp_valid_d = idx_to_onehot(gnt_q);
               result_d    = alu_result_i;
               rsp_error_d = alu_error_i;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         ST_RESP: begin
            // Only the winner's accept matters; everyone else is ignored.
            if (bus.rsp_ready[gnt_q]) begin
               state_d     = ST_IDLE;
               rsp_valid_d = '0;
            end else begin
               state_d = ST_RESP;
            end
         end

         default: begin
            state_d     = ST_IDLE;
            rsp_valid_d = '0;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         gnt_q       <= '0;
         cnt_q       <= '0;
         req_ready_q <= '0;
         rsp_valid_q <= '0;
         alu_valid_q <= 1'b0;
         rsp_error_q <= 1'b0;
         busy_q      <= 1'b0;
         op_q        <= GA_ADD;
         a_q         <= '0;
         b_q         <= '0;
         result_q    <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         gnt_q       <= gnt_d;
         cnt_q       <= cnt_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         alu_valid_q <= alu_valid_d;
         rsp_error_q <= rsp_error_d;
         busy_q      <= busy_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         result_q    <= result_d;
      end
   end

   assign bus.req_ready  = req_ready_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_result = result_q;
   assign bus.rsp_error  = rsp_error_q;
   assign alu_valid_o    = alu_valid_q;
   assign alu_op_o       = op_q;
   assign alu_a_o        = a_q;
   assign alu_b_o        = b_q;
   assign busy_o         = busy_q;

endmodule

// File: tb/tb_ga_alu_arbiter.sv
// Directed bench for ga_alu_arbiter with a small behavioural ga_alu model.
module tb_ga_alu_arbiter;
   import ga_pkg::*;

   localparam int NumReq        = 2;
   localparam int AluLatency    = 2;
   localparam int TimeoutCycles = 15;

   logic            clk;
   logic            rst;
   logic            alu_valid;
   logic            alu_ready;
   logic            alu_error;
   logic            busy;
   ga_funct_e       alu_op;
   ga_multivector_t alu_a;
   ga_multivector_t alu_b;
   ga_multivector_t alu_result;

   ga_alu_arbiter_if #(.NumReq(NumReq)) bus ();

   ga_alu_arbiter #(
      .NumReq        (NumReq),
      .AluLatency    (AluLatency),
      .TimeoutCycles (TimeoutCycles)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .bus          (bus),
      .alu_valid_o  (alu_valid),
      .alu_ready_i  (alu_ready),
      .alu_op_o     (alu_op),
      .alu_a_o      (alu_a),
      .alu_b_o      (alu_b),
      .alu_result_i (alu_result),
      .alu_error_i  (alu_error),
      .busy_o       (busy)
   );

   int checks = 0;
   int errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural ALU: result valid only AluLatency cycles after handshake
   logic      alu_rdy_en;
   int        alu_age;
   ga_funct_e m_op;
   ga_multivector_t m_a, m_b;

   function automatic ga_multivector_t mv_calc(input ga_funct_e op, input ga_multivector_t a,
                                              input ga_multivector_t b);
      logic [7:0][15:0] x, y, r;
      x = a;
      y = b;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         case (op)
            GA_ADD:  r[i] = x[i] + y[i];
            GA_SUB:  r[i] = x[i] - y[i];
            default: r[i] = 16'h0000;
         endcase
      end
      return r;
   endfunction

   assign alu_ready = alu_rdy_en;

   // ALU model: record operands at the handshake and age the operation.
   always @(posedge clk) begin
      if (rst) begin
         alu_age <= 0;
      end else if (alu_valid && alu_ready) begin
         alu_age <= 1;
         m_op    <= alu_op;
         m_a     <= alu_a;
         m_b     <= alu_b;
      end else if (alu_age != 0 && alu_age < 100) begin
         alu_age <= alu_age + 1;
      end
   end

   // ALU model output: garbage outside the one valid cycle.
   always_comb begin
      alu_result = {8{16'hDEAD}};
      alu_error  = 1'b1;
      if (alu_age == AluLatency) begin
         alu_result = mv_calc(m_op, m_a, m_b);
         alu_error  = (m_op == GA_INV);
      end
   end

   // ---------------- helpers
   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy && n < 40) begin
         step();
         n++;
      end
      check(tag, 128'(busy), 128'(1'b0));
   endtask

   ga_multivector_t exp_mv;
   ga_multivector_t hold_a;
   int g_idx[8];
   int g_cyc[8];
   int n_g;
   logic seen0, seen1;

   // Global runaway guard.
   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      rst           = 1'b1;
      alu_rdy_en    = 1'b1;
      bus.req_valid = '0;
      bus.rsp_ready = '0;
      bus.req_op    = {GA_ADD, GA_ADD};
      bus.req_a     = '0;
      bus.req_b     = '0;
      do_reset();

      // ---------------- reset state
      check("rst_req_ready", 128'(bus.req_ready), 128'(2'b00));
      check("rst_rsp_valid", 128'(bus.rsp_valid), 128'(2'b00));
      check("rst_busy",      128'(busy),          128'(1'b0));
      check("rst_alu_valid", 128'(alu_valid),     128'(1'b0));
      check("rst_result",    128'(bus.rsp_result), 128'(0));
      check("rst_error",     128'(bus.rsp_error), 128'(1'b0));
      check("rst_alu_a",     128'(alu_a),         128'(0));

      // ---------------- single op: 3 + 4
      bus.rsp_ready       = 2'b11;
      bus.req_op[0]       = GA_ADD;
      bus.req_a[0]        = '0;
      bus.req_a[0].scalar = 16'd3;
      bus.req_b[0]        = '0;
      bus.req_b[0].scalar = 16'd4;
      bus.req_valid       = 2'b01;
      step();                                           // T
      check("single_grant", 128'(bus.req_ready), 128'(2'b01));
      check("single_busy",  128'(busy),          128'(1'b1));
      bus.req_valid = 2'b00;
      step();                                           // T+1
      check("single_alu_valid", 128'(alu_valid), 128'(1'b1));
      step();
      step();                                           // T+3
      check("single_rsp_early", 128'(bus.rsp_valid), 128'(2'b00));
      step();                                           // T+4
      exp_mv        = '0;
      exp_mv.scalar = 16'd7;
      check("single_rsp_valid", 128'(bus.rsp_valid),  128'(2'b01));
      check("single_result",    128'(bus.rsp_result), 128'(exp_mv));
      check("single_error",     128'(bus.rsp_error),  128'(1'b0));
      step();                                           // T+5
      check("single_rsp_done", 128'(bus.rsp_valid), 128'(2'b00));
      check("single_idle",     128'(busy),          128'(1'b0));

      // ---------------- contention: both request continuously
      do_reset();
      bus.req_op[0]        = GA_ADD;
      bus.req_a[0]         = '0;
      bus.req_a[0].scalar  = 16'd10;
      bus.req_a[0].e1      = 16'd1;
      bus.req_b[0]         = '0;
      bus.req_b[0].scalar  = 16'd5;
      bus.req_b[0].e1      = 16'd2;
      bus.req_op[1]        = GA_SUB;
      bus.req_a[1]         = '0;
      bus.req_a[1].scalar  = 16'd100;
      bus.req_a[1].e12     = 16'd9;
      bus.req_b[1]         = '0;
      bus.req_b[1].scalar  = 16'd40;
      bus.req_b[1].e12     = 16'd4;
      bus.req_valid        = 2'b11;
      n_g   = 0;
      seen0 = 1'b0;
      seen1 = 1'b0;
      for (int c = 0; c < 30; c++) begin
         step();
         if (bus.req_ready != 2'b00 && n_g < 8) begin
            g_idx[n_g] = (bus.req_ready == 2'b10) ? 1 : 0;
            g_cyc[n_g] = c;
            n_g++;
         end
         if (bus.rsp_valid == 2'b01 && !seen0) begin
            seen0         = 1'b1;
            exp_mv        = '0;
            exp_mv.scalar = 16'd15;
            exp_mv.e1     = 16'd3;
            check("cont_result0", 128'(bus.rsp_result), 128'(exp_mv));
         end
         if (bus.rsp_valid == 2'b10 && !seen1) begin
            seen1         = 1'b1;
            exp_mv        = '0;
            exp_mv.scalar = 16'd60;
            exp_mv.e12    = 16'd5;
            check("cont_result1", 128'(bus.rsp_result), 128'(exp_mv));
         end
      end
      bus.req_valid = 2'b00;
      check("cont_ngrants", 128'(n_g >= 4), 128'(1'b1));
      check("cont_g0", 128'(g_idx[0]), 128'(0));
      check("cont_g1", 128'(g_idx[1]), 128'(1));
      check("cont_g2", 128'(g_idx[2]), 128'(0));
      check("cont_g3", 128'(g_idx[3]), 128'(1));
      for (int k = 0; k < 3; k++) begin
         check("cont_gap", 128'(g_cyc[k+1] - g_cyc[k]), 128'(6));
      end
      check("cont_seen_rsp", 128'({seen0, seen1}), 128'(2'b11));
      wait_idle("cont_drain");

      // ---------------- backpressure on requester 1
      do_reset();
      bus.req_op[1]    = GA_SUB;
      bus.req_a[1]     = '0;
      bus.req_a[1].e2  = 16'd20;
      bus.req_b[1]     = '0;
      bus.req_b[1].e2  = 16'd7;
      bus.rsp_ready    = 2'b01;
      bus.req_valid    = 2'b10;
      step();                                           // T
      check("bp_grant", 128'(bus.req_ready), 128'(2'b10));
      bus.req_valid = 2'b01;                            // requester 0 now waits
      step();
      step();
      step();                                           // T+3
      check("bp_rsp_early", 128'(bus.rsp_valid), 128'(2'b00));
      exp_mv    = '0;
      exp_mv.e2 = 16'd13;
      for (int k = 0; k < 6; k++) begin
         step();                                        // T+4+k
         check("bp_hold_valid", 128'(bus.rsp_valid),  128'(2'b10));
         check("bp_hold_result", 128'(bus.rsp_result), 128'(exp_mv));
         check("bp_no_grant",   128'(bus.req_ready),  128'(2'b00));
         if (k == 5) bus.rsp_ready = 2'b11;
      end
      step();                                           // T+10
      check("bp_released", 128'(bus.rsp_valid), 128'(2'b00));
      step();                                           // T+11
      check("bp_next_grant", 128'(bus.req_ready), 128'(2'b01));
      bus.req_valid = 2'b00;
      wait_idle("bp_drain");

      // ---------------- operand hold (pointer is 1, grant wraps to 0)
      bus.req_op[0]   = GA_ADD;
      bus.req_a[0]    = '0;
      bus.req_a[0].e3 = 16'd50;
      bus.req_b[0]    = '0;
      bus.req_b[0].e3 = 16'hFFF8;                       // -8
      hold_a          = bus.req_a[0];
      bus.req_valid   = 2'b01;
      step();                                           // T
      check("hold_grant", 128'(bus.req_ready), 128'(2'b01));
      bus.req_valid   = 2'b00;
      bus.req_a[0].e3 = 16'd1000;
      bus.req_op[0]   = GA_SUB;
      for (int k = 1; k <= 3; k++) begin
         step();
         check("hold_alu_a",  128'(alu_a),  128'(hold_a));
         check("hold_alu_op", 128'(alu_op), 128'(GA_ADD));
      end
      step();                                           // T+4
      exp_mv    = '0;
      exp_mv.e3 = 16'd42;
      check("hold_rsp_valid", 128'(bus.rsp_valid),  128'(2'b01));
      check("hold_result",    128'(bus.rsp_result), 128'(exp_mv));
      wait_idle("hold_drain");

      // ---------------- reset mid-WAIT (pointer is 1 after the last grant)
      bus.req_op[0] = GA_ADD;
      bus.req_valid = 2'b01;
      step();                                           // T
      check("rstw_grant", 128'(bus.req_ready), 128'(2'b01));
      bus.req_valid = 2'b00;
      step();
      step();                                           // T+2: WAIT
      rst = 1'b1;
      step();                                           // T+3
      check("rstw_busy",      128'(busy),           128'(1'b0));
      check("rstw_rsp_valid", 128'(bus.rsp_valid),  128'(2'b00));
      check("rstw_alu_valid", 128'(alu_valid),      128'(1'b0));
      check("rstw_alu_a",     128'(alu_a),          128'(0));
      check("rstw_result",    128'(bus.rsp_result), 128'(0));
      rst           = 1'b0;
      bus.req_valid = 2'b11;
      step();
      check("rstw_ptr_zero", 128'(bus.req_ready), 128'(2'b01));
      bus.req_valid = 2'b00;
      step();
      check("rstw_no_stale_rsp", 128'(bus.rsp_valid), 128'(2'b00));
      wait_idle("rstw_drain");

      // ---------------- error flag from the ALU
      bus.req_op[1] = GA_INV;
      bus.req_valid = 2'b10;
      step();                                           // T
      check("err_grant", 128'(bus.req_ready), 128'(2'b10));
      bus.req_valid = 2'b00;
      step();
      step();
      step();
      step();                                           // T+4
      check("err_rsp_valid", 128'(bus.rsp_valid),  128'(2'b10));
      check("err_flag",      128'(bus.rsp_error),  128'(1'b1));
      check("err_result",    128'(bus.rsp_result), 128'(0));
      wait_idle("err_drain");

`ifdef GA_ALU_ARB_TIMEOUT_EN
      // ---------------- watchdog: ALU never ready
      do_reset();
      alu_rdy_en          = 1'b0;
      bus.req_op[0]       = GA_ADD;
      bus.req_a[0]        = '0;
      bus.req_a[0].scalar = 16'd9;
      bus.req_valid       = 2'b01;
      step();                                           // T
      check("to_grant", 128'(bus.req_ready), 128'(2'b01));
      bus.req_valid = 2'b00;
      for (int k = 1; k <= 16; k++) step();             // T+16
      check("to_rsp_early",  128'(bus.rsp_valid), 128'(2'b00));
      check("to_alu_valid",  128'(alu_valid),     128'(1'b1));
      step();                                           // T+17
      check("to_rsp_valid",  128'(bus.rsp_valid),  128'(2'b01));
      check("to_error",      128'(bus.rsp_error),  128'(1'b1));
      check("to_result",     128'(bus.rsp_result), 128'(0));
      check("to_alu_drop",   128'(alu_valid),      128'(1'b0));
      alu_rdy_en = 1'b1;
      wait_idle("to_drain");
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
